iomem_timer_gpio: RTL and testbench

IOMEM_TIMER_GPIO -- requirements
Module: iomem_timer_gpio

---
 rtl/iomem_timer_gpio.sv | 151 +++++++++++++++
 tb/tb_iomem_timer_gpio.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/iomem_timer_gpio.sv
// iomem_timer_gpio: memory-mapped down-counting timer with expiry interrupt
// plus a GPIO output register and a synchronized GPIO input port.
// Single-cycle-latency bus handshake: accept in IDLE, ready strobe in ACK.
module iomem_timer_gpio #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter int          GPIO_W    = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iomem_valid,
   output logic              iomem_ready,
   input  logic [3:0]        iomem_wstrb,
   input  logic [31:0]       iomem_addr,
   input  logic [31:0]       iomem_wdata,
   output logic [31:0]       iomem_rdata,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq
);

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t            state_q, state_d;
   logic [2:0]        ctrl_q, ctrl_d;       // {IE, AUTO, EN}
   logic [31:0]       load_q, load_d;
   logic [31:0]       count_q, count_d;
   logic              exp_q, exp_d;
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] sync1_q, sync1_d;
   logic [GPIO_W-1:0] sync2_q, sync2_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              irq_q, irq_d;

   logic              sel, accept, wr, exp_set;
   logic [5:0]        off;
   logic [31:0]       rd_val, gpio_out_ext, gpio_in_ext, gpio_wr;
   logic              unused_addr_lsb;

   assign sel             = (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign off             = iomem_addr[7:2];
   assign gpio_out_ext    = 32'(gpio_out_q);
   assign gpio_in_ext     = 32'(sync2_q);
   assign unused_addr_lsb = ^iomem_addr[1:0];

   // Byte-lane merge of write data into an existing 32-bit value.
   function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                          input logic [31:0] wd,
                                          input logic [3:0]  ws);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Handshake FSM next state; a request is only taken in IDLE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: if (iomem_valid && sel) begin
            accept  = 1'b1;
            state_d = S_ACK;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Register file, timer, read mux, irq and input synchronizer next state.
   always_comb begin
      wr         = accept && (iomem_wstrb != 4'h0);
      ctrl_d     = ctrl_q;
      load_d     = load_q;
      gpio_out_d = gpio_out_q;
      gpio_wr    = wmerge(gpio_out_ext, iomem_wdata, iomem_wstrb);

      // Read mux samples registers as they are before the accept edge.
      case (off)
         6'h00:   rd_val = {29'b0, ctrl_q};
         6'h01:   rd_val = load_q;
         6'h02:   rd_val = count_q;
         6'h03:   rd_val = {31'b0, exp_q};
         6'h04:   rd_val = gpio_out_ext;
         6'h05:   rd_val = gpio_in_ext;
         default: rd_val = 32'h0;
      endcase
      rdata_d = accept ? rd_val : 32'h0;

      if (wr) begin
         case (off)
            6'h00: if (iomem_wstrb[0]) ctrl_d = iomem_wdata[2:0];
            6'h01: load_d = wmerge(load_q, iomem_wdata, iomem_wstrb);
            6'h04: gpio_out_d = gpio_wr[GPIO_W-1:0];
            default: ;
         endcase
      end

      // Timer: saturates at 0, reloads from LOAD on expiry when AUTO is set.
      exp_set = ctrl_q[0] && (count_q == 32'd1);
      count_d = count_q;
      if (ctrl_q[0]) begin
         if (count_q > 32'd1)       count_d = count_q - 32'd1;
         else if (count_q == 32'd1) count_d = ctrl_q[1] ? load_q : 32'h0;
      end
      // Bus write to COUNT wins over the timer on the written lanes.
      if (wr && off == 6'h02) count_d = wmerge(count_d, iomem_wdata, iomem_wstrb);

      // W1C of EXP loses against a same-cycle expiry.
      exp_d = exp_q;
      if (wr && off == 6'h03 && iomem_wstrb[0] && iomem_wdata[0]) exp_d = 1'b0;
      if (exp_set) exp_d = 1'b1;

      irq_d   = exp_q & ctrl_q[2];
      sync1_d = gpio_in;
      sync2_d = sync1_q;
   end

   // State registers; synchronous active-low reset drops any in-flight access.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         ctrl_q     <= '0;
         load_q     <= '0;
         count_q    <= '0;
         exp_q      <= 1'b0;
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         load_q     <= load_d;
         count_q    <= count_d;
         exp_q      <= exp_d;
         gpio_out_q <= gpio_out_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign iomem_ready = (state_q == S_ACK);
   assign iomem_rdata = rdata_q;
   assign gpio_out    = gpio_out_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_timer_gpio.sv
// Self-checking bench for iomem_timer_gpio: read expectations are queued
// when a request is driven and compared when the ready strobe appears.
module tb_iomem_timer_gpio;
   localparam logic [31:0] B = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        irq;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] sb[$];

   iomem_timer_gpio #(.BASE_ADDR(B), .GPIO_W(8)) dut (
      .clk(clk), .resetn(resetn),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One bus transaction; reads queue their expectation and compare on ready.
   task automatic bus(input string tag, input logic [31:0] a, input logic [3:0] ws,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
      int          n;
      logic [31:0] e;
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = ws; iomem_wdata = wd;
      if (ws == 4'h0) sb.push_back(exp_rd);
      n = 0;
      do begin @(negedge clk); n++; end while (!iomem_ready && n < 4);
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      if (!iomem_ready) begin
         chk({tag, "_timeout"}, {31'b0, iomem_ready}, 32'd1);
         if (ws == 4'h0) e = sb.pop_front();
      end else if (ws == 4'h0) begin
         e = sb.pop_front();
         chk(tag, iomem_rdata, e);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus("wr", a, 4'hf, d, 32'h0);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
      bus(tag, a, 4'h0, 32'h0, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pulses;
      logic first;
      logic [31:0] rdv;
      resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      iomem_addr = 32'h0; iomem_wdata = 32'h0; gpio_in = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, iomem_ready}, 32'd0);
      chk("rst_rdata", iomem_rdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
      resetn = 1'b1;
      rd("rst_ctrl", B + 32'h00, 32'h0);
      rd("rst_load", B + 32'h04, 32'h0);
      rd("rst_count", B + 32'h08, 32'h0);
      rd("rst_status", B + 32'h0C, 32'h0);
      @(negedge clk);
      chk("rdata_idle", iomem_rdata, 32'h0);

      // Auto-reload timer; transactions land on every other edge (Pw, Pw+2, ...).
      wr(B + 32'h04, 32'd5);
      wr(B + 32'h00, 32'h3);
      wr(B + 32'h08, 32'd3);                    // Pw
      rd("auto_status_pre", B + 32'h0C, 32'h0); // Pw+2: count 2
      rd("auto_count_reload", B + 32'h08, 32'd5); // Pw+4: reloaded at Pw+3
      bus("w1c", B + 32'h0C, 4'h1, 32'h1, 32'h0); // Pw+6
      rd("auto_status_clr", B + 32'h0C, 32'h0); // Pw+8
      rd("auto_status_again", B + 32'h0C, 32'h1); // Pw+10

      // Same-cycle expiry and W1C: expiry wins.
      wr(B + 32'h00, 32'h0);
      bus("w1c", B + 32'h0C, 4'h1, 32'h1, 32'h0);
      rd("race_status_pre", B + 32'h0C, 32'h0);
      wr(B + 32'h08, 32'd2);                    // Pa
      wr(B + 32'h00, 32'h1);                    // Pa+2
      bus("w1c", B + 32'h0C, 4'h1, 32'h1, 32'h0); // Pa+4: 1->0 same edge
      rd("race_status", B + 32'h0C, 32'h1);
      rd("race_count_zero", B + 32'h08, 32'h0);

      // One-shot with interrupt.
      wr(B + 32'h00, 32'h0);
      bus("w1c", B + 32'h0C, 4'h1, 32'h1, 32'h0);
      wr(B + 32'h08, 32'd2);                    // Pa
      wr(B + 32'h00, 32'h5);                    // Pa+2
      @(negedge clk);
      chk("irq_pa3", {31'b0, irq}, 32'd0);
      @(negedge clk);
      chk("irq_pa4", {31'b0, irq}, 32'd0);
      @(negedge clk);
      chk("irq_pa5", {31'b0, irq}, 32'd1);
      rd("oneshot_count", B + 32'h08, 32'h0);
      bus("w1c", B + 32'h0C, 4'h1, 32'h1, 32'h0);
      @(negedge clk);
      chk("irq_cleared", {31'b0, irq}, 32'd0);

      // GPIO: partial-lane write, width truncation, input synchronizer latency.
      bus("gpio_wr", B + 32'h10, 4'h1, 32'hFFFF_FFFF, 32'h0);
      chk("gpio_out_pin", {24'b0, gpio_out}, 32'h0000_00FF);
      bus("gpio_wr_hi", B + 32'h10, 4'h2, 32'h0000_0000, 32'h0);
      rd("gpio_out_rd", B + 32'h10, 32'h0000_00FF);
      gpio_in = 8'hA5;
      rd("gpio_in_early", B + 32'h14, 32'h0);
      rd("gpio_in_sync", B + 32'h14, 32'h0000_00A5);

      // Valid held through the ACK cycle: exactly one ready pulse.
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = B + 32'h04; iomem_wstrb = 4'h0;
      pulses = 0;
      @(negedge clk);
      first = iomem_ready; rdv = iomem_rdata;
      if (iomem_ready) pulses++;
      @(negedge clk);
      if (iomem_ready) pulses++;
      iomem_valid = 1'b0;
      repeat (2) begin @(negedge clk); if (iomem_ready) pulses++; end
      chk("hs_first_ready", {31'b0, first}, 32'd1);
      chk("hs_rdata", rdv, 32'd5);
      chk("hs_pulses", 32'(pulses), 32'd1);

      // Outside the window: never acknowledged.
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = 32'h0400_0000;
      pulses = 0;
      repeat (6) begin @(negedge clk); if (iomem_ready) pulses++; end
      iomem_valid = 1'b0;
      chk("oow_pulses", 32'(pulses), 32'd0);
      wr(B + 32'h40, 32'hDEAD_BEEF);
      rd("unmapped_rd", B + 32'h40, 32'h0);

      // Reset in the accept cycle abandons the write.
      @(negedge clk);
      iomem_valid = 1'b1; iomem_addr = B; iomem_wstrb = 4'hf; iomem_wdata = 32'h1;
      resetn = 1'b0;
      @(negedge clk);
      chk("rst_abort_ready", {31'b0, iomem_ready}, 32'd0);
      chk("rst_abort_gpio", {24'b0, gpio_out}, 32'h0);
      iomem_valid = 1'b0; iomem_wstrb = 4'h0; resetn = 1'b1;
      rd("rst_abort_ctrl", B + 32'h00, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
